fetch_sequencer: RTL and testbench

Program-counter and fetch sequencer that drives the combinational instruction memory and delivers instructions to decode through a valid/ready handshake. It holds the PC, steps it by one 72-bit word (8 address units) per fetch, and buffers fetched words in a small queue so decode back-pressure never loses an instruction. It accepts branch/jump redirects, with flush, and a halt request. It sits between the instruction memory and the decode stage of the 72-bit processor.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_queue.sv | 61 ++++++
 rtl/fetch_sequencer.sv | 80 ++++++++
 tb/tb_fetch_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and widths for the fetch sequencer and its queue.
package fetch_pkg;

  localparam int unsigned ADDR_W  = 72;
  localparam int unsigned INSTR_W = 72;
  localparam int unsigned PC_STEP = 8;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched {instr, pc} entries with flush and same-cycle push/pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             pop_ok;
  logic             push_ok;

  // Pop only a valid head; push into a full queue only when the head leaves.
  always_comb begin
    pop_ok  = pop && (count != '0);
    push_ok = push && ((count < CNT_W'(DEPTH)) || pop_ok);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign valid = (count != '0);

endmodule

// File: rtl/fetch_sequencer.sv
// PC and RUN/HALT control feeding decode from a combinational instruction memory.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned       DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_req,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               out_ready,
  output logic               halted,
  output logic               misalign
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t     state;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0] count;
  logic             pop;
  logic             fetch;
  fetch_entry_t     head;
  fetch_entry_t     new_entry;

  // Fetch when running, nothing higher priority, and the queue has or frees a slot.
  always_comb begin
    pop             = out_valid && out_ready;
    fetch           = (state == RUN) && !redirect_valid && !halt_req &&
                      ((count < CNT_W'(DEPTH)) || pop);
    new_entry.instr = imem_instr;
    new_entry.pc    = pc;
  end

  // PC, state and misalign pulse; redirect beats halt beats fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      pc       <= RESET_PC;
      misalign <= 1'b0;
    end else begin
      misalign <= redirect_valid && (redirect_pc[2:0] != 3'b000);
      if (redirect_valid) begin
        state <= RUN;
        pc    <= {redirect_pc[ADDR_W-1:3], 3'b000};
      end else if ((state == RUN) && halt_req) begin
        state <= HALT;
      end else if (fetch) begin
        pc <= pc + ADDR_W'(PC_STEP);
      end
    end
  end

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (fetch),
    .push_entry(new_entry),
    .pop       (pop),
    .head      (head),
    .valid     (out_valid),
    .count     (count)
  );

  assign imem_addr = pc;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign halted    = (state == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; imem word n holds 0xA0 + n.
module tb_fetch_sequencer;

  localparam int unsigned AW = 72;
  localparam int unsigned IW = 72;
  localparam logic [AW-1:0] TOP_PC    = 72'hFF_FFFF_FFFF_FFFF_FFF8;
  localparam logic [IW-1:0] TOP_INSTR = 72'h20_0000_0000_0000_009F;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_instr;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          halt_req;
  logic          out_valid;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic          out_ready;
  logic          halted;
  logic          misalign;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign imem_instr = IW'(72'hA0) + IW'(imem_addr[AW-1:3]);

  fetch_sequencer #(.DEPTH(2), .RESET_PC('0)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt_req      (halt_req),
    .out_valid     (out_valid),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_ready     (out_ready),
    .halted        (halted),
    .misalign      (misalign)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt_req       = 1'b0;
    out_ready      = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_head(input string name, input logic v, input logic [AW-1:0] pc,
                          input logic [IW-1:0] ins);
    n_vec++;
    if (out_valid !== v || (v && (out_pc !== pc || out_instr !== ins))) begin
      n_err++;
      $display("FAIL %s: got valid=%b pc=%h instr=%h, want valid=%b pc=%h instr=%h",
               name, out_valid, out_pc, out_instr, v, pc, ins);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0; out_ready = 1'b0;
    #3;
    n_vec++;
    if ({out_valid, halted, misalign} !== 3'b000 || out_instr !== '0 || out_pc !== '0 ||
        imem_addr !== '0) begin
      n_err++;
      $display("FAIL reset: got v=%b h=%b m=%b instr=%h pc=%h addr=%h, want all zero",
               out_valid, halted, misalign, out_instr, out_pc, imem_addr);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    chk_head("stream_empty", 1'b0, '0, '0);
    tick(); chk_head("stream_0",  1'b1, 72'd0,  72'hA0);
    tick(); chk_head("stream_8",  1'b1, 72'd8,  72'hA1);
    tick(); chk_head("stream_16", 1'b1, 72'd16, 72'hA2);
    tick(); chk_head("stream_24", 1'b1, 72'd24, 72'hA3);
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_head("bp_hold", 1'b1, 72'd0, 72'hA0);
    end
    n_vec++;
    if (imem_addr !== 72'd16) begin
      n_err++;
      $display("FAIL bp_addr: got %h want %h", imem_addr, 72'd16);
    end
    out_ready = 1'b1;
    chk_head("bp_rel_0",  1'b1, 72'd0,  72'hA0);
    tick(); chk_head("bp_rel_8",  1'b1, 72'd8,  72'hA1);
    tick(); chk_head("bp_rel_16", 1'b1, 72'd16, 72'hA2);
    tick(); chk_head("bp_rel_24", 1'b1, 72'd24, 72'hA3);
  endtask

  task automatic test_redirect();
    do_reset();
    tick(); tick();
    redirect_valid = 1'b1;
    redirect_pc    = 72'h40;
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    n_vec++;
    if (imem_addr !== 72'h40 || out_valid !== 1'b0 || misalign !== 1'b0) begin
      n_err++;
      $display("FAIL redir_flush: got addr=%h v=%b m=%b want addr=40 v=0 m=0",
               imem_addr, out_valid, misalign);
    end
    tick(); chk_head("redir_first", 1'b1, 72'h40, 72'hA8);
  endtask

  task automatic test_misalign();
    do_reset();
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 72'h43;
    tick();
    redirect_valid = 1'b0;
    n_vec++;
    if (misalign !== 1'b1 || imem_addr !== 72'h40) begin
      n_err++;
      $display("FAIL misalign_pulse: got m=%b addr=%h want m=1 addr=40", misalign, imem_addr);
    end
    tick();
    n_vec++;
    if (misalign !== 1'b0) begin
      n_err++;
      $display("FAIL misalign_clear: got %b want 0", misalign);
    end
  endtask

  task automatic test_halt();
    do_reset();
    tick(); tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    halt_req  = 1'b1;
    tick();
    halt_req  = 1'b0;
    out_ready = 1'b1;
    n_vec++;
    if (halted !== 1'b1 || imem_addr !== 72'd24) begin
      n_err++;
      $display("FAIL halt_enter: got h=%b addr=%h want h=1 addr=18", halted, imem_addr);
    end
    chk_head("halt_drain_8", 1'b1, 72'd8, 72'hA1);
    tick(); chk_head("halt_drain_16", 1'b1, 72'd16, 72'hA2);
    halt_req = 1'b1;
    tick();
    chk_head("halt_empty", 1'b0, '0, '0);
    n_vec++;
    if (halted !== 1'b1 || imem_addr !== 72'd24) begin
      n_err++;
      $display("FAIL halt_hold: got h=%b addr=%h want h=1 addr=18", halted, imem_addr);
    end
    halt_req       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 72'd24;
    tick();
    redirect_valid = 1'b0;
    n_vec++;
    if (halted !== 1'b0 || imem_addr !== 72'd24) begin
      n_err++;
      $display("FAIL halt_resume: got h=%b addr=%h want h=0 addr=18", halted, imem_addr);
    end
    tick(); chk_head("halt_resume_24", 1'b1, 72'd24, 72'hA3);
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = TOP_PC;
    tick();
    redirect_valid = 1'b0;
    tick(); chk_head("wrap_top", 1'b1, TOP_PC, TOP_INSTR);
    n_vec++;
    if (imem_addr !== '0) begin
      n_err++;
      $display("FAIL wrap_addr: got %h want 0", imem_addr);
    end
    tick(); chk_head("wrap_zero", 1'b1, 72'd0, 72'hA0);
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if ({out_valid, halted, misalign} !== 3'b000 || out_instr !== '0 || out_pc !== '0 ||
        imem_addr !== '0) begin
      n_err++;
      $display("FAIL midreset: got v=%b h=%b m=%b instr=%h pc=%h addr=%h, want all zero",
               out_valid, halted, misalign, out_instr, out_pc, imem_addr);
    end
    tick();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misalign();
    test_halt();
    test_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
